// File: rtl/phaser_in_tap_ctrl_if.sv
// Request/status bundle of phaser_in_tap_ctrl: rank/lane select, tap step/load/read
// requests, divider reset request and the registered status outputs.
interface phaser_in_tap_ctrl_if #(
    parameter int NUM_LANES = 2,
    parameter int TAP_WIDTH = 6
);
    logic                           DIVIDERST;
    logic [1:0]                     RANKSEL;
    logic [1:0]                     LANESEL;
    logic                           FINEENABLE;
    logic                           FINEINC;
    logic                           COUNTERLOADEN;
    logic [TAP_WIDTH-1:0]           COUNTERLOADVAL;
    logic                           COUNTERREADEN;
    logic [TAP_WIDTH-1:0]           COUNTERREADVAL;
    logic                           FINEOVERFLOW;
    logic [NUM_LANES*TAP_WIDTH-1:0] TAPVAL;
    logic                           BUSY;
    logic                           ISERDESRST;

    modport master (
        output DIVIDERST, RANKSEL, LANESEL, FINEENABLE, FINEINC,
               COUNTERLOADEN, COUNTERLOADVAL, COUNTERREADEN,
        input  COUNTERREADVAL, FINEOVERFLOW, TAPVAL, BUSY, ISERDESRST
    );

    modport slave (
        input  DIVIDERST, RANKSEL, LANESEL, FINEENABLE, FINEINC,
               COUNTERLOADEN, COUNTERLOADVAL, COUNTERREADEN,
        output COUNTERREADVAL, FINEOVERFLOW, TAPVAL, BUSY, ISERDESRST
    );
endinterface

// File: rtl/phaser_in_tap_ctrl.sv
// Multi-rank, multi-lane fine-delay tap controller with settle-window rank switching
// and ISERDESRST pulse sequencing for the capture SERDES.
module phaser_in_tap_ctrl #(
    parameter int    NUM_RANKS        = 4,
    parameter int    NUM_LANES        = 2,
    parameter int    TAP_WIDTH        = 6,
    parameter int    FINE_DELAY       = 0,
    parameter string WRAP_MODE        = "SATURATE",
    parameter int    SETTLE_CYCLES    = 4,
    parameter string EN_ISERDES_RST   = "FALSE",
    parameter int    RST_PULSE_CYCLES = 8
) (
    input logic                 SYSCLK,
    input logic                 RST,
    phaser_in_tap_ctrl_if.slave bus
);
    localparam logic [TAP_WIDTH-1:0] TMAX        = '1;
    localparam logic [TAP_WIDTH-1:0] TAP_INIT    = TAP_WIDTH'(FINE_DELAY);
    localparam logic [1:0]           RANK_MAX    = 2'(NUM_RANKS - 1);
    localparam logic [1:0]           LANE_MAX    = 2'(NUM_LANES - 1);
    localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [4:0]           PULSE_LOAD  = 5'(RST_PULSE_CYCLES);
    localparam bit                   WRAP_EN     = (WRAP_MODE == "WRAP");
    localparam bit                   ISR_EN      = (EN_ISERDES_RST == "TRUE");

    typedef enum logic { RS_IDLE, RS_SWITCH } rank_state_e;
    typedef enum logic { IR_HOLD, IR_OFF }    isr_state_e;

    logic [TAP_WIDTH-1:0]           tap_q [NUM_RANKS][NUM_LANES];
    logic [TAP_WIDTH-1:0]           tap_d [NUM_RANKS][NUM_LANES];
    logic [NUM_LANES*TAP_WIDTH-1:0] tapval_q, tapval_d;
    logic [TAP_WIDTH-1:0]           readval_q, readval_d;
    logic                           fine_ovf_q, fine_ovf_d;
    logic                           busy_q, busy_d;
    logic                           iserdesrst_q, iserdesrst_d;

    rank_state_e                    rank_state_q, rank_state_d;
    logic [1:0]                     active_rank_q, active_rank_d;
    logic [1:0]                     pending_rank_q, pending_rank_d;
    logic [3:0]                     settle_cnt_q, settle_cnt_d;

    isr_state_e                     isr_state_q, isr_state_d;
    logic [4:0]                     isr_cnt_q, isr_cnt_d;

    logic [1:0]                     rank_req;
    logic                           lane_ok;
    logic [TAP_WIDTH-1:0]           sel_tap;
    logic [TAP_WIDTH-1:0]           new_tap;
    logic                           tap_wr;

    // Tap datapath: select, step/load, read capture of the pre-update value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        rank_req   = (bus.RANKSEL > RANK_MAX) ? RANK_MAX : bus.RANKSEL;
        lane_ok    = (bus.LANESEL <= LANE_MAX);
        sel_tap    = '0;
        new_tap    = '0;
        tap_wr     = 1'b0;
        fine_ovf_d = fine_ovf_q;
        readval_d  = readval_q;
        tap_d      = tap_q;

        for (int r = 0; r < NUM_RANKS; r++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (2'(r) == active_rank_q && 2'(l) == bus.LANESEL) begin
                    sel_tap = tap_q[r][l];
                end
            end
        end

        if (bus.COUNTERREADEN && lane_ok) begin
            readval_d = sel_tap;
        end

        if (!busy_q && lane_ok) begin
            if (bus.COUNTERLOADEN) begin
                tap_wr     = 1'b1;
                new_tap    = bus.COUNTERLOADVAL;
                fine_ovf_d = 1'b0;
            end else if (bus.FINEENABLE) begin
                tap_wr = 1'b1;
                if (bus.FINEINC) begin
                    if (sel_tap == TMAX) begin
                        fine_ovf_d = 1'b1;
                        new_tap    = WRAP_EN ? '0 : TMAX;
                    end else begin
                        new_tap = sel_tap + 1'b1;
                    end
                end else begin
                    if (sel_tap == '0) begin
                        fine_ovf_d = 1'b1;
                        new_tap    = WRAP_EN ? TMAX : '0;
                    end else begin
                        new_tap = sel_tap - 1'b1;
                    end
                end
            end
        end

        for (int r = 0; r < NUM_RANKS; r++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (tap_wr && 2'(r) == active_rank_q && 2'(l) == bus.LANESEL) begin
                    tap_d[r][l] = new_tap;
                end
            end
        end
    end

    // Rank switch: a new request (or a retarget mid-switch) restarts the settle window.
    always_comb begin
        rank_state_d   = rank_state_q;
        active_rank_d  = active_rank_q;
        pending_rank_d = pending_rank_q;
        settle_cnt_d   = settle_cnt_q;
        busy_d         = busy_q;

        case (rank_state_q)
            RS_IDLE: begin
                if (rank_req != active_rank_q) begin
                    pending_rank_d = rank_req;
                    settle_cnt_d   = SETTLE_LOAD;
                    rank_state_d   = RS_SWITCH;
                    busy_d         = 1'b1;
                end
            end
            RS_SWITCH: begin
                if (rank_req != pending_rank_q) begin
                    pending_rank_d = rank_req;
                    settle_cnt_d   = SETTLE_LOAD;
                end else if (settle_cnt_q <= 4'd1) begin
                    active_rank_d = pending_rank_q;
                    rank_state_d  = RS_IDLE;
                    busy_d        = 1'b0;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            default: begin
                rank_state_d = RS_IDLE;
                busy_d       = 1'b0;
            end
        endcase
    end

    // TAPVAL follows the next-state taps of the next-state rank so it flips with BUSY.
    always_comb begin
        tapval_d = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                if (2'(r) == active_rank_d) begin
                    tapval_d[l*TAP_WIDTH +: TAP_WIDTH] = tap_d[r][l];
                end
            end
        end
    end

    always_comb begin
        isr_state_d  = isr_state_q;
        isr_cnt_d    = isr_cnt_q;
        iserdesrst_d = iserdesrst_q;

        if (ISR_EN) begin
            case (isr_state_q)
                IR_HOLD: begin
                    if (bus.DIVIDERST) begin
                        isr_cnt_d = PULSE_LOAD;
                    end else if (isr_cnt_q <= 5'd1) begin
                        isr_state_d  = IR_OFF;
                        iserdesrst_d = 1'b0;
                    end else begin
                        isr_cnt_d = isr_cnt_q - 5'd1;
                    end
                end
                IR_OFF: begin
                    if (bus.DIVIDERST) begin
                        isr_state_d  = IR_HOLD;
                        isr_cnt_d    = PULSE_LOAD;
                        iserdesrst_d = 1'b1;
                    end
                end
                default: begin
                    isr_state_d  = IR_HOLD;
                    isr_cnt_d    = PULSE_LOAD;
                    iserdesrst_d = 1'b1;
                end
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            // NOTE: the tap array is reset on purpose: every tap must come up at FINE_DELAY.
            for (int r = 0; r < NUM_RANKS; r++) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    tap_q[r][l] <= TAP_INIT;
                end
            end
            tapval_q       <= {NUM_LANES{TAP_INIT}};
            readval_q      <= '0;
            fine_ovf_q     <= 1'b0;
            busy_q         <= 1'b0;
            rank_state_q   <= RS_IDLE;
            active_rank_q  <= '0;
            pending_rank_q <= '0;
            settle_cnt_q   <= '0;
            isr_state_q    <= IR_HOLD;
            isr_cnt_q      <= PULSE_LOAD;
            iserdesrst_q   <= ISR_EN;
        end else begin
            tap_q          <= tap_d;
            tapval_q       <= tapval_d;
            readval_q      <= readval_d;
            fine_ovf_q     <= fine_ovf_d;
            busy_q         <= busy_d;
            rank_state_q   <= rank_state_d;
            active_rank_q  <= active_rank_d;
            pending_rank_q <= pending_rank_d;
            settle_cnt_q   <= settle_cnt_d;
            isr_state_q    <= isr_state_d;
            isr_cnt_q      <= isr_cnt_d;
            iserdesrst_q   <= iserdesrst_d;
        end
    end

    assign bus.TAPVAL         = tapval_q;
    assign bus.COUNTERREADVAL = readval_q;
    assign bus.FINEOVERFLOW   = fine_ovf_q;
    assign bus.BUSY           = busy_q;
    assign bus.ISERDESRST     = iserdesrst_q;
endmodule

// File: tb/tb_phaser_in_tap_ctrl.sv
// Scoreboard bench for phaser_in_tap_ctrl: instance A (4 ranks, SATURATE, ISERDESRST on)
// and instance B (2 ranks, WRAP, ISERDESRST off), both with FINE_DELAY=5.
module tb_phaser_in_tap_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phaser_in_tap_ctrl_if #(.NUM_LANES(2), .TAP_WIDTH(6)) ia ();
    phaser_in_tap_ctrl_if #(.NUM_LANES(2), .TAP_WIDTH(6)) ib ();

    phaser_in_tap_ctrl #(
        .NUM_RANKS(4), .NUM_LANES(2), .TAP_WIDTH(6), .FINE_DELAY(5),
        .WRAP_MODE("SATURATE"), .SETTLE_CYCLES(4),
        .EN_ISERDES_RST("TRUE"), .RST_PULSE_CYCLES(8)
    ) dut_a (
        .SYSCLK (clk),
        .RST    (rst),
        .bus    (ia.slave)
    );

    phaser_in_tap_ctrl #(
        .NUM_RANKS(2), .NUM_LANES(2), .TAP_WIDTH(6), .FINE_DELAY(5),
        .WRAP_MODE("WRAP"), .SETTLE_CYCLES(4),
        .EN_ISERDES_RST("FALSE"), .RST_PULSE_CYCLES(8)
    ) dut_b (
        .SYSCLK (clk),
        .RST    (rst),
        .bus    (ib.slave)
    );

    typedef enum {A_TAPVAL, A_RDVAL, A_OVF, A_BUSY, A_ISR,
                  B_TAPVAL, B_RDVAL, B_OVF, B_BUSY, B_ISR} sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            A_TAPVAL: return 32'(ia.TAPVAL);
            A_RDVAL:  return 32'(ia.COUNTERREADVAL);
            A_OVF:    return 32'(ia.FINEOVERFLOW);
            A_BUSY:   return 32'(ia.BUSY);
            A_ISR:    return 32'(ia.ISERDESRST);
            B_TAPVAL: return 32'(ib.TAPVAL);
            B_RDVAL:  return 32'(ib.COUNTERREADVAL);
            B_OVF:    return 32'(ib.FINEOVERFLOW);
            B_BUSY:   return 32'(ib.BUSY);
            default:  return 32'(ib.ISERDESRST);
        endcase
    endfunction

    // Packs the two 6-bit lane taps as they appear on TAPVAL.
    function automatic logic [31:0] tv(input int l1, input int l0);
        return 32'((l1 << 6) | l0);
    endfunction

    task automatic push_exp(input string tag, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic clear_pulses();
        ia.FINEENABLE = 1'b0; ia.COUNTERLOADEN = 1'b0; ia.COUNTERREADEN = 1'b0; ia.DIVIDERST = 1'b0;
        ib.FINEENABLE = 1'b0; ib.COUNTERLOADEN = 1'b0; ib.COUNTERREADEN = 1'b0; ib.DIVIDERST = 1'b0;
    endtask

    // One clock: the edge samples the driven requests, then queued expectations are checked.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
        clear_pulses();
    endtask

    initial begin
        ia.RANKSEL = '0; ia.LANESEL = '0; ia.FINEINC = 1'b0; ia.COUNTERLOADVAL = '0;
        ib.RANKSEL = '0; ib.LANESEL = '0; ib.FINEINC = 1'b0; ib.COUNTERLOADVAL = '0;
        clear_pulses();

        repeat (3) @(posedge clk);
        #1;
        check("rst_tapval_a", observe(A_TAPVAL), 32'h145);
        check("rst_busy_a",   observe(A_BUSY),   0);
        check("rst_ovf_a",    observe(A_OVF),    0);
        check("rst_rdval_a",  observe(A_RDVAL),  0);
        check("rst_isr_a",    observe(A_ISR),    1);
        check("rst_isr_b",    observe(B_ISR),    0);
        check("rst_tapval_b", observe(B_TAPVAL), 32'h145);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push_exp("isr_release", A_ISR, 32'(i < 8));
            tick();
        end

        // Saturating steps at TMAX on A lane 1.
        ia.LANESEL = 2'd1; ia.COUNTERLOADEN = 1'b1; ia.COUNTERLOADVAL = 6'd62;
        push_exp("sat_load62", A_TAPVAL, tv(62, 5));
        push_exp("sat_load62_ovf", A_OVF, 0);
        tick();
        ia.FINEINC = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ia.FINEENABLE = 1'b1;
            push_exp("sat_step", A_TAPVAL, tv(63, 5));
            push_exp("sat_step_ovf", A_OVF, 32'(i > 0));
            tick();
        end
        ia.COUNTERLOADEN = 1'b1; ia.COUNTERLOADVAL = 6'd10;
        push_exp("sat_load10", A_TAPVAL, tv(10, 5));
        push_exp("sat_load10_ovf", A_OVF, 0);
        tick();
        ia.COUNTERREADEN = 1'b1; ia.COUNTERLOADEN = 1'b1; ia.COUNTERLOADVAL = 6'd20;
        push_exp("read_pre_load", A_RDVAL, 10);
        push_exp("load20", A_TAPVAL, tv(20, 5));
        tick();
        ia.COUNTERLOADEN = 1'b1; ia.COUNTERLOADVAL = 6'd33; ia.FINEENABLE = 1'b1;
        push_exp("load_over_step", A_TAPVAL, tv(33, 5));
        tick();
        ia.LANESEL = 2'd0; ia.FINEINC = 1'b0; ia.FINEENABLE = 1'b1;
        push_exp("dec_lane0", A_TAPVAL, tv(33, 4));
        tick();
        ia.LANESEL = 2'd2; ia.FINEENABLE = 1'b1; ia.COUNTERREADEN = 1'b1;
        push_exp("bad_lane_step", A_TAPVAL, tv(33, 4));
        push_exp("bad_lane_read", A_RDVAL, 10);
        tick();

        // Wrapping steps on B lane 0.
        ib.LANESEL = 2'd0; ib.COUNTERLOADEN = 1'b1; ib.COUNTERLOADVAL = 6'd0;
        push_exp("wrap_load0", B_TAPVAL, tv(5, 0));
        push_exp("wrap_load0_ovf", B_OVF, 0);
        tick();
        ib.FINEENABLE = 1'b1; ib.FINEINC = 1'b0; ib.COUNTERREADEN = 1'b1;
        push_exp("wrap_dec", B_TAPVAL, tv(5, 63));
        push_exp("wrap_dec_ovf", B_OVF, 1);
        push_exp("wrap_dec_read", B_RDVAL, 0);
        tick();
        ib.FINEENABLE = 1'b1; ib.FINEINC = 1'b1;
        push_exp("wrap_inc", B_TAPVAL, tv(5, 0));
        push_exp("wrap_inc_ovf", B_OVF, 1);
        tick();
        ib.COUNTERLOADEN = 1'b1; ib.COUNTERLOADVAL = 6'd1;
        push_exp("wrap_load1", B_TAPVAL, tv(5, 1));
        push_exp("wrap_load1_ovf", B_OVF, 0);
        tick();

        // Rank switch 0 -> 2 on A with requests dropped while busy.
        ia.LANESEL = 2'd0; ia.COUNTERLOADEN = 1'b1; ia.COUNTERLOADVAL = 6'd7;
        push_exp("r0_load7", A_TAPVAL, tv(33, 7));
        tick();
        ia.RANKSEL = 2'd2;
        push_exp("sw_busy", A_BUSY, 1);
        push_exp("sw_tapval", A_TAPVAL, tv(33, 7));
        tick();
        ia.FINEENABLE = 1'b1; ia.FINEINC = 1'b1; ia.COUNTERREADEN = 1'b1;
        push_exp("sw_busy", A_BUSY, 1);
        push_exp("sw_step_drop", A_TAPVAL, tv(33, 7));
        push_exp("sw_read_busy", A_RDVAL, 7);
        tick();
        ia.COUNTERLOADEN = 1'b1; ia.COUNTERLOADVAL = 6'd50;
        push_exp("sw_busy", A_BUSY, 1);
        push_exp("sw_load_drop", A_TAPVAL, tv(33, 7));
        tick();
        push_exp("sw_busy", A_BUSY, 1);
        push_exp("sw_tapval", A_TAPVAL, tv(33, 7));
        tick();
        push_exp("sw_done", A_BUSY, 0);
        push_exp("sw_r2_tapval", A_TAPVAL, tv(5, 5));
        tick();
        ia.FINEENABLE = 1'b1;
        push_exp("r2_step", A_TAPVAL, tv(5, 6));
        tick();
        ia.RANKSEL = 2'd0;
        for (int i = 0; i < 5; i++) begin
            push_exp("back_busy", A_BUSY, 32'(i < 4));
            push_exp("back_tapval", A_TAPVAL, (i < 4) ? tv(5, 6) : tv(33, 7));
            tick();
        end

        // Retarget mid-switch: 1 then 3.
        ia.RANKSEL = 2'd1;
        push_exp("rt_busy", A_BUSY, 1);
        tick();
        push_exp("rt_busy", A_BUSY, 1);
        tick();
        ia.RANKSEL = 2'd3;
        for (int i = 0; i < 5; i++) begin
            push_exp("rt3_busy", A_BUSY, 32'(i < 4));
            push_exp("rt3_tapval", A_TAPVAL, (i < 4) ? tv(33, 7) : tv(5, 5));
            tick();
        end
        push_exp("rt3_settled", A_BUSY, 0);
        tick();

        // Clamp on B: RANKSEL=3 with two ranks selects rank 1.
        ib.RANKSEL = 2'd3;
        for (int i = 0; i < 5; i++) begin
            push_exp("clamp_busy", B_BUSY, 32'(i < 4));
            push_exp("clamp_tapval", B_TAPVAL, (i < 4) ? tv(5, 1) : tv(5, 5));
            tick();
        end
        ib.RANKSEL = 2'd1;
        push_exp("clamp_same", B_BUSY, 0);
        tick();

        // Divider reset pulses on A, and no effect on B.
        for (int i = 0; i < 9; i++) begin
            if (i == 0) ia.DIVIDERST = 1'b1;
            push_exp("divrst_pulse", A_ISR, 32'(i < 8));
            tick();
        end
        for (int i = 0; i < 14; i++) begin
            if (i == 0 || i == 5) ia.DIVIDERST = 1'b1;
            if (i == 0) begin
                ib.DIVIDERST = 1'b1;
                push_exp("divrst_off_b", B_ISR, 0);
            end
            push_exp("divrst_extend", A_ISR, 32'(i < 13));
            tick();
        end

        // Asynchronous reset during a switch.
        ia.LANESEL = 2'd1; ia.COUNTERLOADEN = 1'b1; ia.COUNTERLOADVAL = 6'd40;
        push_exp("r3_load40", A_TAPVAL, tv(40, 5));
        tick();
        ia.RANKSEL = 2'd1;
        push_exp("pre_rst_busy", A_BUSY, 1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("async_busy",   observe(A_BUSY),   0);
        check("async_tapval", observe(A_TAPVAL), 32'h145);
        check("async_rdval",  observe(A_RDVAL),  0);
        check("async_isr",    observe(A_ISR),    1);
        ia.RANKSEL = 2'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        push_exp("post_rst_busy", A_BUSY, 0);
        push_exp("post_rst_tapval", A_TAPVAL, tv(5, 5));
        push_exp("post_rst_isr", A_ISR, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
